// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor blocks.
// Holds the flush FSM states, counter arithmetic and geometry helpers.
package bp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } bp_state_t;

    function automatic int idx_w(int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(int sets);
        return 30 - $clog2(sets);
    endfunction

    // Weakly-taken counter value, zero-extended to the widest counter.
    function automatic logic [2:0] cnt_weak_t(int w);
        return 3'(1 << (w - 1));
    endfunction

    // Saturating up/down step for a w-bit counter held in 3 bits.
    function automatic logic [2:0] sat_update(
        logic [2:0] cnt,
        logic       up,
        int         w
    );
        logic [2:0] top;
        top = 3'((1 << w) - 1);
        if (up)
            return (cnt == top) ? cnt : cnt + 3'd1;
        else
            return (cnt == 3'd0) ? cnt : cnt - 3'd1;
    endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the BTB: valid, tag, target and counter per set.
// Ports: lookup read (rd_*), update read (up_*), write (wr_*), valid clear (clr_*).
module btb_way
    import bp_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int CNT_W = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [idx_w(SETS)-1:0]      rd_idx,
    output logic                        rd_valid,
    output logic [tag_w(SETS)-1:0]      rd_tag,
    output logic [31:0]                 rd_target,
    output logic [CNT_W-1:0]            rd_cnt,
    input  logic [idx_w(SETS)-1:0]      up_idx,
    output logic                        up_valid,
    output logic [tag_w(SETS)-1:0]      up_tag,
    output logic [31:0]                 up_target,
    output logic [CNT_W-1:0]            up_cnt,
    input  logic                        wr_en,
    input  logic [idx_w(SETS)-1:0]      wr_idx,
    input  logic [tag_w(SETS)-1:0]      wr_tag,
    input  logic [31:0]                 wr_target,
    input  logic [CNT_W-1:0]            wr_cnt,
    input  logic                        clr_en,
    input  logic [idx_w(SETS)-1:0]      clr_idx
);

    localparam int TAG_W = tag_w(SETS);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q    [SETS];
    logic [31:0]      target_q [SETS];
    logic [CNT_W-1:0] cnt_q    [SETS];

    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_target = target_q[rd_idx];
    assign rd_cnt    = cnt_q[rd_idx];

    assign up_valid  = valid_q[up_idx];
    assign up_tag    = tag_q[up_idx];
    assign up_target = target_q[up_idx];
    assign up_cnt    = cnt_q[up_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            if (clr_en)
                valid_q[clr_idx] <= 1'b0;
            if (wr_en) begin
                valid_q[wr_idx]  <= 1'b1;
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= wr_target;
                cnt_q[wr_idx]    <= wr_cnt;
            end
        end
    end

endmodule

// File: rtl/btb_2way.sv
// Two-way set-associative BTB with saturating direction counters and LRU.
// Ports: pc -> hit/pred_taken/pred_pc; upd_* trains; flush_req/busy sequence a flush.
module btb_2way
    import bp_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int CNT_W = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        hit,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        flush_req,
    output logic        busy
);

    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(SETS);
    localparam logic [2:0] WEAK3 = cnt_weak_t(CNT_W);
    localparam logic [CNT_W-1:0] CNT_WEAK_T = WEAK3[CNT_W-1:0];
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

    bp_state_t state_q, state_d;
    logic [IDX_W-1:0] fcnt_q;
    logic [SETS-1:0]  lru_q;

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;

    logic             r_v0, r_v1, u_v0, u_v1;
    logic [TAG_W-1:0] r_tag0, r_tag1, u_tag0, u_tag1;
    logic [31:0]      r_tgt0, r_tgt1, u_tgt0, u_tgt1;
    logic [CNT_W-1:0] r_cnt0, r_cnt1, u_cnt0, u_cnt1;

    logic             wr_go, wr_sel, wr_en0, wr_en1;
    logic [CNT_W-1:0] wr_cnt;
    logic [31:0]      wr_tgt;

    logic unused_lsb;
    assign unused_lsb = ^{pc[1:0], upd_pc[1:0]};

    assign l_idx = pc[IDX_W+1:2];
    assign l_tag = pc[31:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];

    btb_way #(.SETS(SETS), .CNT_W(CNT_W)) u_way0 (
        .clock     (clock),
        .reset     (reset),
        .rd_idx    (l_idx),
        .rd_valid  (r_v0),
        .rd_tag    (r_tag0),
        .rd_target (r_tgt0),
        .rd_cnt    (r_cnt0),
        .up_idx    (u_idx),
        .up_valid  (u_v0),
        .up_tag    (u_tag0),
        .up_target (u_tgt0),
        .up_cnt    (u_cnt0),
        .wr_en     (wr_en0),
        .wr_idx    (u_idx),
        .wr_tag    (u_tag),
        .wr_target (wr_tgt),
        .wr_cnt    (wr_cnt),
        .clr_en    (busy),
        .clr_idx   (fcnt_q)
    );

    btb_way #(.SETS(SETS), .CNT_W(CNT_W)) u_way1 (
        .clock     (clock),
        .reset     (reset),
        .rd_idx    (l_idx),
        .rd_valid  (r_v1),
        .rd_tag    (r_tag1),
        .rd_target (r_tgt1),
        .rd_cnt    (r_cnt1),
        .up_idx    (u_idx),
        .up_valid  (u_v1),
        .up_tag    (u_tag1),
        .up_target (u_tgt1),
        .up_cnt    (u_cnt1),
        .wr_en     (wr_en1),
        .wr_idx    (u_idx),
        .wr_tag    (u_tag),
        .wr_target (wr_tgt),
        .wr_cnt    (wr_cnt),
        .clr_en    (busy),
        .clr_idx   (fcnt_q)
    );

    // Flush FSM: state register, next state, outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (flush_req) state_d = FLUSH;
            FLUSH: if (fcnt_q == LAST_SET) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == FLUSH);
    end

    // fcnt wraps back to 0 naturally after the last set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            fcnt_q <= '0;
        else if (state_q == IDLE)
            fcnt_q <= '0;
        else
            fcnt_q <= fcnt_q + 1'b1;
    end

    // Lookup: way 0 wins if both ways ever match.
    logic l_h0, l_h1;

    always_comb begin
        l_h0       = r_v0 && (r_tag0 == l_tag);
        l_h1       = r_v1 && (r_tag1 == l_tag);
        hit        = !busy && (l_h0 || l_h1);
        pred_pc    = 32'b0;
        pred_taken = 1'b0;
        if (hit) begin
            pred_pc    = l_h0 ? r_tgt0 : r_tgt1;
            pred_taken = l_h0 ? r_cnt0[CNT_W-1] : r_cnt1[CNT_W-1];
        end
    end

    // Update: train the hitting way, or allocate a victim on a taken miss.
    logic             u_go, u_h0, u_h1, u_hit, victim;
    logic [CNT_W-1:0] old_cnt;
    logic [2:0]       sat3;

    always_comb begin
        u_go    = upd_valid && (state_q == IDLE) && !flush_req;
        u_h0    = u_v0 && (u_tag0 == u_tag);
        u_h1    = u_v1 && (u_tag1 == u_tag);
        u_hit   = u_h0 || u_h1;
        victim  = !u_v0 ? 1'b0 : (!u_v1 ? 1'b1 : lru_q[u_idx]);
        wr_sel  = u_hit ? !u_h0 : victim;
        old_cnt = wr_sel ? u_cnt1 : u_cnt0;
        sat3    = sat_update(3'(old_cnt), upd_taken, CNT_W);
        wr_go   = u_go && (u_hit || upd_taken);
        wr_en0  = wr_go && !wr_sel;
        wr_en1  = wr_go && wr_sel;
        wr_cnt  = u_hit ? sat3[CNT_W-1:0] : CNT_WEAK_T;
        wr_tgt  = upd_target;
        if (u_hit && !upd_taken)
            wr_tgt = wr_sel ? u_tgt1 : u_tgt0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            lru_q <= '0;
        else if (busy)
            lru_q[fcnt_q] <= 1'b0;
        else if (wr_go)
            lru_q[u_idx] <= !wr_sel;
    end

endmodule

// File: tb/tb_btb_2way.sv
// Randomized and directed checks of btb_2way against a recency-based model.
// Model keeps per-entry PCs and last-use timestamps instead of LRU bits.
module tb_btb_2way;

    localparam int SETS = 16;
    localparam int CMAX = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic        hit, pred_taken, busy;
    logic [31:0] pred_pc;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        flush_req = 1'b0;

    int errors = 0;
    int checks = 0;

    btb_2way #(.SETS(SETS), .CNT_W(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .pc         (pc),
        .hit        (hit),
        .pred_taken (pred_taken),
        .pred_pc    (pred_pc),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .flush_req  (flush_req),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    bit          mv  [2][SETS];
    int unsigned mpc [2][SETS];
    int unsigned mtgt[2][SETS];
    int          mcnt[2][SETS];
    longint      mst [2][SETS];
    longint      now;
    int          fl;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int set_of(input logic [31:0] a);
        return int'(a[5:2]);
    endfunction

    function automatic int unsigned key(input logic [31:0] a);
        return a >> 6;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < SETS; s++) begin
                mv[w][s] = 0; mpc[w][s] = 0; mtgt[w][s] = 0;
                mcnt[w][s] = 0; mst[w][s] = 0;
            end
        now = 0;
        fl = 0;
    endtask

    function automatic int find(input logic [31:0] a);
        int s = set_of(a);
        for (int w = 0; w < 2; w++)
            if (mv[w][s] && mpc[w][s] == key(a)) return w;
        return -1;
    endfunction

    task automatic model_update(input logic [31:0] a, input bit t,
                                input logic [31:0] tg);
        int s = set_of(a);
        int w = find(a);
        now++;
        if (w >= 0) begin
            if (t) mcnt[w][s] = (mcnt[w][s] < CMAX) ? mcnt[w][s] + 1 : CMAX;
            else   mcnt[w][s] = (mcnt[w][s] > 0) ? mcnt[w][s] - 1 : 0;
            if (t) mtgt[w][s] = tg;
            mst[w][s] = now;
        end else if (t) begin
            if (!mv[0][s])      w = 0;
            else if (!mv[1][s]) w = 1;
            else                w = (mst[0][s] < mst[1][s]) ? 0 : 1;
            mv[w][s] = 1; mpc[w][s] = key(a); mtgt[w][s] = tg;
            mcnt[w][s] = 2; mst[w][s] = now;
        end
    endtask

    // One clock cycle: drive, check lookup against model, advance model.
    task automatic drive(input logic [31:0] p, input bit uv,
                         input logic [31:0] up, input bit ut,
                         input logic [31:0] utg, input bit fr);
        int w;
        pc = p; upd_valid = uv; upd_pc = up; upd_taken = ut;
        upd_target = utg; flush_req = fr;
        #1;
        w = find(p);
        if (fl > 0) w = -1;
        check("hit", {31'b0, hit}, {31'b0, w >= 0});
        check("pred_taken", {31'b0, pred_taken},
              {31'b0, (w >= 0) && mcnt[w < 0 ? 0 : w][set_of(p)] >= 2});
        check("pred_pc", pred_pc, (w >= 0) ? mtgt[w][set_of(p)] : 32'b0);
        check("busy", {31'b0, busy}, {31'b0, fl > 0});
        if (fl > 0) begin
            mv[0][SETS-fl] = 0; mv[1][SETS-fl] = 0;
            fl--;
        end else if (fr) begin
            fl = SETS;
        end else if (uv) begin
            model_update(up, ut, utg);
        end
        @(posedge clock);
        #1;
        upd_valid = 1'b0; flush_req = 1'b0;
    endtask

    task automatic look(input logic [31:0] p);
        drive(p, 0, 0, 0, 0, 0);
    endtask

    task automatic train(input logic [31:0] a, input bit t,
                         input logic [31:0] tg);
        drive(a, 1, a, t, tg, 0);
    endtask

    int bcnt;

    initial begin
        model_reset();
        pc = 32'h100;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_hit", {31'b0, hit}, 32'd0);
        check("rst_pc", pred_pc, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Cold allocation
        look(32'h100);
        train(32'h100, 1, 32'h200);
        check("alloc_hit", {31'b0, hit}, 32'd1);
        check("alloc_tk", {31'b0, pred_taken}, 32'd1);
        check("alloc_pc", pred_pc, 32'h200);

        // Counter saturation
        train(32'h100, 0, 32'h0);
        check("nt1_tk", {31'b0, pred_taken}, 32'd0);
        train(32'h100, 0, 32'h0);
        train(32'h100, 0, 32'h0);
        check("nt3_hit", {31'b0, hit}, 32'd1);
        check("nt3_pc", pred_pc, 32'h200);
        repeat (4) train(32'h100, 1, 32'h200);
        check("sat_tk", {31'b0, pred_taken}, 32'd1);
        train(32'h100, 0, 32'h0);
        check("sat_m1", {31'b0, pred_taken}, 32'd1);
        train(32'h100, 0, 32'h0);
        check("sat_m2", {31'b0, pred_taken}, 32'd0);

        // Set conflict and LRU
        train(32'h500, 1, 32'h600);
        train(32'h900, 1, 32'ha00);
        look(32'h500);
        check("lru_500", {31'b0, hit}, 32'd1);
        look(32'h100);
        check("lru_100", {31'b0, hit}, 32'd0);
        look(32'h900);
        check("lru_900", pred_pc, 32'ha00);

        // Not-taken miss
        train(32'h300, 0, 32'h0);
        look(32'h300);
        check("nt_miss", {31'b0, hit}, 32'd0);

        // Flush with an injected update
        train(32'h304, 1, 32'h1304);
        train(32'h408, 1, 32'h1408);
        drive(32'h500, 0, 0, 0, 0, 1);
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) bcnt++;
            drive(32'h500, i == 3, 32'h60c, 1, 32'h777, 0);
        end
        check("busy_len", bcnt, SETS);
        look(32'h500);  check("fl_500", {31'b0, hit}, 32'd0);
        look(32'h900);  check("fl_900", {31'b0, hit}, 32'd0);
        look(32'h304);  check("fl_304", {31'b0, hit}, 32'd0);
        look(32'h408);  check("fl_408", {31'b0, hit}, 32'd0);
        look(32'h60c);  check("fl_drop", {31'b0, hit}, 32'd0);

        // Reset mid-flush
        train(32'h100, 1, 32'h200);
        drive(32'h100, 0, 0, 0, 0, 1);
        repeat (5) look(32'h100);
        reset = 1'b1;
        #1;
        check("rmf_busy", {31'b0, busy}, 32'd0);
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        look(32'h100);
        check("rmf_miss", {31'b0, hit}, 32'd0);
        train(32'h100, 1, 32'h240);
        check("rmf_alloc", pred_pc, 32'h240);

        // Random traffic over a small PC pool to force conflicts
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, u, t;
            a = 32'(($urandom_range(0, 5) << 6) | ($urandom_range(0, 3) << 2));
            u = 32'(($urandom_range(0, 5) << 6) | ($urandom_range(0, 3) << 2));
            t = $urandom & 32'hffff_fffc;
            drive(a, $urandom_range(0, 3) != 0, u, $urandom_range(0, 2) != 0,
                  t, $urandom_range(0, 59) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
